// File: rtl/snake_input.sv
// Direction button conditioning: sync, debounce, press detect,
// and a 2-entry press FIFO presented one-hot to the control logic.
module snake_input #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_btn,
    input  logic       i_step,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic [1:0] o_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    st;
    logic [CW-1:0] cnt [4];
    logic [3:0]    press;

    logic [1:0] mem0;
    logic [1:0] mem1;
    logic [1:0] count;
    logic [1:0] code;
    logic [1:0] newest;
    logic       push;
    logic       pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            st <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1 <= i_btn;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CMAX) begin
                    st[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // A press is an accepted 0->1 change of the stable level.
    always_comb begin
        for (int i = 0; i < 4; i++)
            press[i] = s2[i] && !st[i] && (cnt[i] == CMAX);
    end

    always_comb begin
        code = 2'd0;
        priority case (1'b1)
            press[0]: code = 2'd0;
            press[1]: code = 2'd1;
            press[2]: code = 2'd2;
            press[3]: code = 2'd3;
            default:  code = 2'd0;
        endcase
        newest = (count == 2'd2) ? mem1 : mem0;
        push = (|press) && !((count != 2'd0) && (code == newest));
        pop  = i_step && (count != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= '0;
        end else if (push && pop) begin
            if (count == 2'd1) begin
                mem0 <= code;
            end else begin
                mem0 <= mem1;
                mem1 <= code;
            end
        end else if (pop) begin
            mem0  <= mem1;
            count <= count - 2'd1;
        end else if (push) begin
            if (count == 2'd0) begin
                mem0  <= code;
                count <= 2'd1;
            end else if (count == 2'd1) begin
                mem1  <= code;
                count <= 2'd2;
            end
        end
    end

    always_comb begin
        o_up    = 1'b0;
        o_down  = 1'b0;
        o_left  = 1'b0;
        o_right = 1'b0;
        if (count != 2'd0) begin
            unique case (mem0)
                2'd0: o_up    = 1'b1;
                2'd1: o_down  = 1'b1;
                2'd2: o_left  = 1'b1;
                2'd3: o_right = 1'b1;
                default: o_up = 1'b0;
            endcase
        end
        o_count = count;
    end

endmodule

// File: tb/tb_snake_input.sv
// Directed self-checking bench for snake_input.
module tb_snake_input;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_btn;
    logic       i_step;
    logic       o_up;
    logic       o_down;
    logic       o_left;
    logic       o_right;
    logic [1:0] o_count;

    int checks;
    int failures;

    snake_input #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_btn(i_btn),
        .i_step(i_step),
        .o_up(o_up),
        .o_down(o_down),
        .o_left(o_left),
        .o_right(o_right),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] dirs,
                             input logic [1:0] cnt);
        chk({tag, ".dirs"}, {o_right, o_left, o_down, o_up}, dirs);
        chk({tag, ".count"}, {2'b00, o_count}, {2'b00, cnt});
    endtask

    task automatic press(input int idx);
        i_btn[idx] = 1'b1;
        tick(8);
        i_btn[idx] = 1'b0;
        tick(8);
    endtask

    task automatic step_pulse();
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_btn    = 4'b0000;
        i_step   = 1'b0;
        tick(2);
        chk_state("reset", 4'b0000, 2'd0);

        // up held from before edge 1
        i_btn[0] = 1'b1;
        rst_n    = 1'b1;
        tick(5);
        chk_state("up_edge5", 4'b0000, 2'd0);
        tick(1);
        chk_state("up_edge6", 4'b0001, 2'd1);
        i_btn[0] = 1'b0;
        tick(8);
        chk_state("up_release", 4'b0001, 2'd1);
        step_pulse();
        chk_state("up_pop", 4'b0000, 2'd0);

        // glitchy left never accepted
        for (int i = 0; i < 40; i++) begin
            i_btn[2] = (i % 3 == 0);
            tick(1);
        end
        chk_state("glitch", 4'b0000, 2'd0);
        i_btn[2] = 1'b0;
        tick(6);
        chk_state("glitch_settle", 4'b0000, 2'd0);

        // two queued presses then pops
        press(0);
        press(2);
        chk_state("fifo2", 4'b0001, 2'd2);
        step_pulse();
        chk_state("fifo_pop1", 4'b0100, 2'd1);
        step_pulse();
        chk_state("fifo_pop2", 4'b0000, 2'd0);
        step_pulse();
        chk_state("pop_empty", 4'b0000, 2'd0);

        // full drop and duplicate drop
        press(0);
        press(2);
        press(3);
        chk_state("full_drop", 4'b0001, 2'd2);
        step_pulse();
        chk_state("pre_dup", 4'b0100, 2'd1);
        press(2);
        chk_state("dup_drop", 4'b0100, 2'd1);
        step_pulse();
        chk_state("dup_empty", 4'b0000, 2'd0);

        // simultaneous up+right, then push with pop
        i_btn = 4'b1001;
        tick(8);
        i_btn = 4'b0000;
        tick(8);
        chk_state("prio", 4'b0001, 2'd1);
        i_btn[1] = 1'b1;
        tick(5);
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        chk_state("push_pop", 4'b0010, 2'd1);
        i_btn[1] = 1'b0;
        tick(8);
        step_pulse();
        chk_state("pp_empty", 4'b0000, 2'd0);

        // reset mid-operation with up held
        press(0);
        press(2);
        chk_state("pre_rst", 4'b0001, 2'd2);
        i_btn[0] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk_state("mid_rst", 4'b0000, 2'd0);
        rst_n = 1'b1;
        tick(5);
        chk_state("rst_edge5", 4'b0000, 2'd0);
        tick(1);
        chk_state("rst_edge6", 4'b0001, 2'd1);
        i_btn[0] = 1'b0;
        tick(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
